// File: rtl/ps2_pkg.sv
// Shared constants, decoder states and the 10-bit key event record for the PS/2 key decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXT  = 2'd1,
        ST_BRK  = 2'd2
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Storage is not reset, so the head is masked to zero while empty.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode byte decoder producing make/break events into a FIFO.
// Define PS2_REPEAT_FILTER_EN to suppress typematic repeats of the last held key.
//
// state | meaning
// IDLE  | waiting for first byte of a code
// EXT   | E0 prefix seen, ext flag set
// BRK   | F0 prefix seen, next byte is a release
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    output logic             ps2_nextdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic [CNT_W-1:0] fifo_count,
    input  logic             ovf_clr,
    output logic             overflow,
    output logic             err
);

    ps2_state_t state_q, state_d;
    logic       ext_q, ext_d;
    logic       capture;
    logic       is_err;
    logic       emit;
    ps2_evt_t   evt;
    logic       suppress;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    ps2_evt_t   head;

    assign capture = ps2_ready & ~ps2_nextdata;
    assign is_err  = (ps2_data == PS2_ERR0) || (ps2_data == PS2_ERR1);

    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        emit     = 1'b0;
        evt.ext  = ext_q;
        evt.brk  = 1'b0;
        evt.code = ps2_data;
        if (capture) begin
            if (is_err) begin
                state_d = ST_IDLE;
                ext_d   = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_EXT: begin
                        if (ps2_data == PS2_EXT) begin
                            state_d = ST_EXT;
                            ext_d   = 1'b1;
                        end else if (ps2_data == PS2_BRK) begin
                            state_d = ST_BRK;
                        end else begin
                            emit    = 1'b1;
                            state_d = ST_IDLE;
                            ext_d   = 1'b0;
                        end
                    end
                    ST_BRK: begin
                        emit    = 1'b1;
                        evt.brk = 1'b1;
                        state_d = ST_IDLE;
                        ext_d   = 1'b0;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        ext_d   = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ext_q        <= 1'b0;
            ps2_nextdata <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            ext_q        <= ext_d;
            ps2_nextdata <= capture;
            err          <= capture & is_err;
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic       trk_valid;
    logic [8:0] trk_key;
    logic       trk_match;

    assign trk_match = trk_valid && (trk_key == {evt.ext, evt.code});
    assign suppress  = emit & ~evt.brk & trk_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            trk_valid <= 1'b0;
            trk_key   <= '0;
        end else if (emit && !evt.brk) begin
            trk_valid <= 1'b1;
            trk_key   <= {evt.ext, evt.code};
        end else if (emit && evt.brk && trk_match) begin
            trk_valid <= 1'b0;
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign push = emit & ~suppress;
    assign pop  = evt_ready & ~empty;

    sync_fifo #(
        .WIDTH ($bits(ps2_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (evt),
        .pop   (evt_ready),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign evt_valid = ~empty;
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;

    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder with hand-computed expected events.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_nextdata;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [3:0] fifo_count;
    logic       ovf_clr;
    logic       overflow;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int bytes_sent = 0;
    logic err_seen;

    ps2_key_decoder #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_data     (ps2_data),
        .ps2_ready    (ps2_ready),
        .ps2_nextdata (ps2_nextdata),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_break    (evt_break),
        .fifo_count   (fifo_count),
        .ovf_clr      (ovf_clr),
        .overflow     (overflow),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ps2_nextdata) pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one byte; capture happens at the next rising edge, the pop pulse one cycle later.
    task automatic send_byte(input logic [7:0] b, input logic with_ready);
        @(negedge clk);
        ps2_data  = b;
        ps2_ready = 1'b1;
        evt_ready = with_ready;
        @(negedge clk);
        ps2_ready = 1'b0;
        evt_ready = 1'b0;
        err_seen  = err;
        bytes_sent++;
        @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic ext, input logic brk, input logic [7:0] code);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
        chk({tag, "_evt"}, {22'd0, evt_ext, evt_break, evt_code}, {22'd0, ext, brk, code});
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ps2_data = 8'h00; ps2_ready = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_next", 32'(ps2_nextdata), 32'd0);
        chk("rst_head", {22'd0, evt_ext, evt_break, evt_code}, 32'd0);

        // make and break of 1C
        send_byte(8'h1C, 1'b0);
        chk("make_err", 32'(err_seen), 32'd0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk("mk_count", 32'(fifo_count), 32'd2);
        pop_check("mk1c", 1'b0, 1'b0, 8'h1C);
        pop_check("bk1c", 1'b0, 1'b1, 8'h1C);
        chk("pulses3", 32'(pulses), 32'(bytes_sent));

        // extended make and break
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        pop_check("mk75", 1'b1, 1'b0, 8'h75);
        pop_check("bk75", 1'b1, 1'b1, 8'h75);
        chk("empty_ext", 32'(evt_valid), 32'd0);

        // fill beyond depth
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1'b0);
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("ovf_set", 32'(overflow), 32'd1);
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // push into full FIFO while popping
        send_byte(8'h20, 1'b1);
        chk("fullpop_count", 32'(fifo_count), 32'd8);
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 8; i++) pop_check("drain", 1'b0, 1'b0, 8'h10 + 8'(i));
        pop_check("drain20", 1'b0, 1'b0, 8'h20);
        chk("drained", 32'(evt_valid), 32'd0);
        chk("drained_cnt", 32'(fifo_count), 32'd0);

        // reset abandons pending E0
        send_byte(8'hE0, 1'b0);
        do_reset();
        send_byte(8'h1C, 1'b0);
        pop_check("postrst", 1'b0, 1'b0, 8'h1C);

        // error byte
        send_byte(8'hFF, 1'b0);
        chk("err_pulse", 32'(err_seen), 32'd1);
        chk("err_gone", 32'(err), 32'd0);
        chk("err_noevt", 32'(evt_valid), 32'd0);
        chk("pulses_all", 32'(pulses), 32'(bytes_sent));

        // typematic repeat sequence
        do_reset();
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
`ifdef PS2_REPEAT_FILTER_EN
        chk("rep_count", 32'(fifo_count), 32'd3);
        pop_check("rep_mk", 1'b0, 1'b0, 8'h1C);
        pop_check("rep_bk", 1'b0, 1'b1, 8'h1C);
        pop_check("rep_mk2", 1'b0, 1'b0, 8'h1C);
`else
        chk("rep_count", 32'(fifo_count), 32'd5);
        for (int i = 0; i < 3; i++) pop_check("rep_mk", 1'b0, 1'b0, 8'h1C);
        pop_check("rep_bk", 1'b0, 1'b1, 8'h1C);
        pop_check("rep_mk2", 1'b0, 1'b0, 8'h1C);
`endif
        chk("rep_empty", 32'(evt_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
